// File: rtl/parqueo_pkg.sv
// Shared types for the parking-spot input conditioning and availability decoding.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package parqueo_pkg;

    localparam int N_SPOTS = 4;
    localparam int OCC_W   = 3;

    typedef logic [N_SPOTS-1:0] spot_vec_t;

    // Number of occupied spots in an occupancy vector.
    function automatic logic [OCC_W-1:0] popcount(input spot_vec_t v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/parqueo_sensores_debounce_canal.sv
// One spot channel: two-flop synchroniser followed by a restart-on-glitch debouncer.
// Latency: a held raw change reaches level on the 2+DEBOUNCE_CYCLES th edge after it is first sampled.
// Backpressure: none; rise/fall flag the acceptance that level takes on the coming edge.
module debounce_canal
    import parqueo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Debounce: any return of sync to stable throws away all accumulated progress.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Edge flags are combinational so the top can register them alongside the new level.
    assign level = stable_q;
    assign rise  = accept & sync_q;
    assign fall  = accept & ~sync_q;

endmodule

// File: rtl/parqueo_sensores.sv
// Conditions four raw spot sensors into clean occupancy bits, a count and arrival/departure strobes.
// Latency: 2+DEBOUNCE_CYCLES edges from first sample to p/occ_count/arr/dep, all on the same edge.
// Backpressure: none; outputs are valid every cycle.
module parqueo_sensores
    import parqueo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    output logic             p1,
    output logic             p2,
    output logic             p3,
    output logic             p4,
    output logic [OCC_W-1:0] occ_count,
    output logic [3:0]       arr,
    output logic [3:0]       dep
);

    spot_vec_t        raw_vec;
    spot_vec_t        level_vec;
    spot_vec_t        rise_vec;
    spot_vec_t        fall_vec;
    spot_vec_t        level_nxt;
    logic [OCC_W-1:0] occ_q, occ_d;
    spot_vec_t        arr_q;
    spot_vec_t        dep_q;

    assign raw_vec = {s4, s3, s2, s1};

    for (genvar i = 0; i < N_SPOTS; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_canal (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[i]),
            .level (level_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );
    end

    // Occupancy the channels will hold after this edge, so the count lines up with p1..p4.
    always_comb begin
        level_nxt = (level_vec | rise_vec) & ~fall_vec;
        occ_d     = popcount(level_nxt);
    end

    // Count and strobes register on the same edge the channel levels change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
            arr_q <= '0;
            dep_q <= '0;
        end else begin
            occ_q <= occ_d;
            arr_q <= rise_vec;
            dep_q <= fall_vec;
        end
    end

    assign p1        = level_vec[0];
    assign p2        = level_vec[1];
    assign p3        = level_vec[2];
    assign p4        = level_vec[3];
    assign occ_count = occ_q;
    assign arr       = arr_q;
    assign dep       = dep_q;

endmodule

// File: tb/tb_parqueo_sensores.sv
// Bench for parqueo_sensores with DEBOUNCE_CYCLES = 4: expected outputs are queued per cycle.
// Latency: stimulus driven after posedge n is expected to be accepted at posedge n+6.
// Backpressure: none.
module tb_parqueo_sensores;

    logic       clk;
    logic       rst_n;
    logic       s1, s2, s3, s4;
    logic       p1, p2, p3, p4;
    logic [2:0] occ_count;
    logic [3:0] arr, dep;

    parqueo_sensores #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .s4        (s4),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .occ_count (occ_count),
        .arr       (arr),
        .dep       (dep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] arr;
        logic [3:0] dep;
        logic [2:0] occ;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_check = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_check++;
        if (obs !== exp_v)
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
        else
            n_pass++;
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] a,
                        input logic [3:0] d, input logic [2:0] o, input string tag);
        exp_t e;
        int   idx;
        e.cyc = c; e.p = p; e.arr = a; e.dep = d; e.occ = o; e.tag = tag;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    // Change driven after posedge n: old state at n+5, new state plus strobes at n+6, strobes gone at n+7.
    task automatic expect_change(input int n, input logic [3:0] p_old, input logic [3:0] p_new,
                                 input logic [3:0] a, input logic [3:0] d,
                                 input logic [2:0] o_old, input logic [2:0] o_new, input string tag);
        push(n + 5, p_old, 4'b0, 4'b0, o_old, {tag, "_pre"});
        push(n + 6, p_new, a,    d,    o_new, {tag, "_acc"});
        push(n + 7, p_new, 4'b0, 4'b0, o_new, {tag, "_post"});
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Scoreboard drain: compare every queued expectation due this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk({e.tag, "_missed"}, 8'(cyc), 8'(e.cyc));
            end else begin
                chk({e.tag, "_p"},   {4'b0, p4, p3, p2, p1}, {4'b0, e.p});
                chk({e.tag, "_arr"}, {4'b0, arr},            {4'b0, e.arr});
                chk({e.tag, "_dep"}, {4'b0, dep},            {4'b0, e.dep});
                chk({e.tag, "_occ"}, {5'b0, occ_count},      {5'b0, e.occ});
            end
        end
    end

    initial begin
        int n;
        int budget;

        // Reset with all sensors high: outputs stay clear while reset is held.
        s1 = 1'b1; s2 = 1'b1; s3 = 1'b1; s4 = 1'b1;
        rst_n = 1'b0;
        for (int c = 1; c <= 3; c++) push(c, 4'b0000, 4'b0, 4'b0, 3'd0, "reset_hold");
        tick(3);
        rst_n = 1'b1;
        n = cyc;
        expect_change(n, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 3'd0, 3'd4, "reset_rel");
        tick(10);

        // Return all spots to free.
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
        n = cyc;
        expect_change(n, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 3'd4, 3'd0, "all_free");
        tick(10);

        // Clean step up and down on spot 1.
        s1 = 1'b1;
        n = cyc;
        expect_change(n, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 3'd0, 3'd1, "step_up");
        tick(10);
        s1 = 1'b0;
        n = cyc;
        expect_change(n, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 3'd1, 3'd0, "step_dn");
        tick(10);

        // Glitch on spot 2 lasting three cycles is filtered.
        n = cyc;
        for (int c = n + 1; c <= n + 10; c++) push(c, 4'b0000, 4'b0, 4'b0, 3'd0, "glitch");
        s2 = 1'b1;
        tick(3);
        s2 = 1'b0;
        tick(10);

        // Bounce on spot 3, then hold high; acceptance counts from the final rise.
        n = cyc;
        for (int c = n + 1; c <= n + 8; c++) push(c, 4'b0000, 4'b0, 4'b0, 3'd0, "bounce_hold");
        s3 = 1'b1; tick(1);
        s3 = 1'b0; tick(1);
        s3 = 1'b1; tick(1);
        s3 = 1'b0; tick(1);
        s3 = 1'b1;
        n = cyc;
        expect_change(n, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 3'd0, 3'd1, "bounce");
        tick(10);

        // Move the occupied spot from 3 to 4, then back, with simultaneous changes.
        s3 = 1'b0; s4 = 1'b1;
        n = cyc;
        expect_change(n, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 3'd1, 3'd1, "simul_a");
        tick(10);
        s3 = 1'b1; s4 = 1'b0;
        n = cyc;
        expect_change(n, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 3'd1, 3'd1, "simul_b");
        tick(10);

        // Spot 1 rises; a one-edge reset at the 4th edge clears everything and restarts qualification.
        s1 = 1'b1;
        n = cyc;
        for (int c = n + 1; c <= n + 3; c++) push(c, 4'b0100, 4'b0, 4'b0, 3'd1, "midrst_pre");
        push(n + 4, 4'b0000, 4'b0, 4'b0, 3'd0, "midrst_edge");
        for (int c = n + 5; c <= n + 9; c++) push(c, 4'b0000, 4'b0, 4'b0, 3'd0, "midrst_wait");
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        expect_change(cyc, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 3'd0, 3'd2, "midrst");
        tick(10);

        budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (sb.size() > 0) chk("drain_timeout", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/parqueo_sensores.md
# parqueo_sensores

Input conditioning stage for the parking-lot availability logic. Takes the four raw, asynchronous, bouncy spot sensors, synchronises and debounces each one, and drives clean occupancy bits `p1..p4` straight into the adjacent-free-space decoder. Also produces a registered occupancy count and per-spot arrival/departure strobes for display and counting logic.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles a synchronised input needs before it is accepted. Legal range is ≥1; 0 is illegal.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of each debounce counter. Derived; do not override.
- `clk`  in  1  system clock. This is the one clock; all state is on its rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `s1`, `s2`, `s3`, `s4`  in  1 each  raw spot sensors, asynchronous. 1 = car present.
- `p1`, `p2`, `p3`, `p4`  out  1 each  debounced occupancy, registered. 1 = occupied. These feed the availability decoder.
- `occ_count`  out  3  number of occupied spots, 0..4, registered.
- `arr`  out  4  one-cycle strobe per spot on a 0→1 accepted change. Bit 0 = spot 1.
- `dep`  out  4  one-cycle strobe per spot on a 1→0 accepted change. Bit 0 = spot 1.

## Operation
- Each spot has its own two-flop synchroniser: `sN` → `meta` → `sync`.
- Each spot has its own debounce state:
  - Registers: `stable` (drives `pN`) and `cnt[CNT_W-1:0]`.
  - `sync == stable` → `cnt <= 0`.
  - `sync != stable` and `cnt < DEBOUNCE_CYCLES-1` → `cnt <= cnt+1`.
  - `sync != stable` and `cnt == DEBOUNCE_CYCLES-1` → `stable <= sync`, `cnt <= 0`.
- Any return of `sync` to `stable` before acceptance discards all progress. There is no partial credit.
- Strobes and count:
  - `arr[i]` / `dep[i]` are registered. They are high in exactly the cycle in which `pN` first shows its new value.
  - `occ_count` is the popcount of the next `stable` vector, registered on the same edge. It is therefore always consistent with `p1..p4` in the same cycle.
- Channels are fully independent. Any number of spots may change on the same edge, in either direction. `occ_count` reflects the net result, and `arr`/`dep` may each carry several bits at once.

## Timing
- Reset values (edge with `rst_n == 0`): `meta`, `sync`, `stable`, `cnt` = 0. This gives `p1..p4` = 0 (all free), `occ_count` = 0, `arr` = `dep` = 0.
- Reset asserted mid-debounce aborts the pending change. After release the input must requalify from scratch.
- Acceptance latency: a raw change held steady is accepted at the 2+`DEBOUNCE_CYCLES` th rising edge after the first edge that samples it. `pN`, `occ_count` and the strobe update on that edge.
- First-sample jitter: an input change landing asynchronously may add one cycle of uncertainty before the first sampling edge.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` cycles at `sync`. Anything shorter is filtered completely.
- Strobe width: exactly one cycle. A channel cannot strobe again sooner than `DEBOUNCE_CYCLES` cycles later.
- No handshake and no backpressure. Consumers sample `p1..p4` every cycle.

## Structure
- Shared package `parqueo_pkg` holds:
  - `N_SPOTS = 4`
  - `OCC_W = 3`
  - the occupancy vector typedef `spot_vec_t = logic [N_SPOTS-1:0]`
  - the availability decoder also uses this package.
- Sub-module `debounce_canal`, instantiated 4 times:
  - Contents: synchroniser, counter, `stable` flop, rise/fall strobe generation.
  - Ports: `clk`, `rst_n`, `raw`, `level`, `rise`, `fall`; parameter `DEBOUNCE_CYCLES`.
- Top level holds only the instances, the vector packing and the registered popcount.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 4`.
- **Reset:** `s = 1111` with `rst_n` low for 3 edges → `p = 0000`, `occ_count = 0`, `arr = dep = 0` throughout. After release → `p = 1111` on the 6th edge, `arr = 1111` for one cycle, `occ_count = 4`.
- **Clean step:** `s1` 0→1 and held → `p1` rises on the 6th edge, `arr = 0001` for exactly one cycle, `occ_count` 0→1 on the same edge. Then `s1` 1→0 → `dep = 0001` 6 edges later, `occ_count` 1→0.
- **Glitch reject:** `s2` high for 3 cycles then low → `p2` stays 0, no strobe, `occ_count` unchanged.
- **Bounce:** `s3` toggles 1,0,1,0,1 on successive cycles and then holds 1 → `p3` rises exactly 6 edges after the final 0→1, with a single `arr[2]` pulse.
- **Simultaneous:** `p = 1000`; `s3` rises while `s4` falls on the same cycle → on one edge `p = 0100`, `arr = 0100`, `dep = 1000`, `occ_count` stays 1.
- **Reset mid-debounce:** `s1` rises, `rst_n` pulsed low for 1 edge at the 4th edge → `p1` rises 6 edges after release, not earlier.
